// File: rtl/blue_ctrl_if.sv
// Bus bundle for blue_ctrl: key inputs, scan coordinates in, sprite
// address / state / position out.
// master = scan/keyboard side, slave = blue_ctrl.
interface blue_ctrl_if;
    logic        key_left;
    logic        key_right;
    logic        key_jump;
    logic [9:0]  col;
    logic [9:0]  row;
    logic [11:0] blue;
    logic        blue_on;
    logic [2:0]  blue_state;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;

    modport master (
        output key_left, key_right, key_jump, col, row,
        input  blue, blue_on, blue_state, pos_x, pos_y
    );

    modport slave (
        input  key_left, key_right, key_jump, col, row,
        output blue, blue_on, blue_state, pos_x, pos_y
    );
endinterface

// File: rtl/blue_ctrl.sv
// blue_ctrl: motion and sprite-address generator for the blue character.
// Keys are sampled once per move tick; x saturates inside the screen,
// y follows a ground/rise/fall jump FSM. For every scan pixel a registered
// unflipped sprite ROM address and an inside flag are produced.
// Optional feature macro: BLUE_DOUBLE_JUMP_EN (one mid-air re-jump on a
// rising edge of key_jump, re-armed on landing).
module blue_ctrl #(
    parameter int SPR_W    = 47,
    parameter int SPR_H    = 64,
    parameter int SCR_W    = 640,
    parameter int X_INIT   = 100,
    parameter int Y_GROUND = 416,
    parameter int STEP     = 2,
    parameter int JUMP_V0  = 12,
    parameter int GRAV     = 1,
    parameter int TICK_DIV = 833333
) (
    input  logic        clk,
    input  logic        rst_n,
    blue_ctrl_if.slave  bus
);

    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int X_MAX = SCR_W - SPR_W;

    localparam logic signed [11:0] Y_GND = 12'(Y_GROUND);
    localparam logic signed [11:0] V0    = 12'(JUMP_V0);
    localparam logic signed [11:0] G     = 12'(GRAV);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } vstate_e;

    logic [TW-1:0]      tick_cnt_q;
    logic               tick;

    logic [9:0]         x_q, x_d;
    logic               facing_q, facing_d;
    logic               move_q, move_d;

    vstate_e            vs_q, vs_d;
    logic signed [11:0] y_q, y_d;
    logic signed [11:0] vy_q, vy_d;
    logic signed [11:0] vy_dec;
    logic signed [11:0] vy_inc;
    logic signed [11:0] y_sum;

    logic [11:0]        blue_q, blue_d;
    logic               blue_on_q, blue_on_d;

`ifdef BLUE_DOUBLE_JUMP_EN
    logic               jump_prev_q, jump_prev_d;
    logic               armed_q, armed_d;
    logic               jump_edge;
`endif

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    // Free-running move-tick divider; restarts at 0 on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
        end
    end

    // Horizontal motion: one key held moves and sets facing, else idle.
    always_comb begin
        x_d      = x_q;
        facing_d = facing_q;
        move_d   = move_q;
        if (tick) begin
            if (bus.key_left ^ bus.key_right) begin
                move_d = 1'b1;
                if (bus.key_right) begin
                    facing_d = 1'b1;
                    x_d = (x_q >= 10'(X_MAX - STEP)) ? 10'(X_MAX) : x_q + 10'(STEP);
                end else begin
                    facing_d = 1'b0;
                    x_d = (x_q <= 10'(STEP)) ? 10'd0 : x_q - 10'(STEP);
                end
            end else begin
                move_d = 1'b0;
            end
        end
    end

    assign vy_dec = vy_q - G;
    assign vy_inc = vy_q + G;
    assign y_sum  = y_q + vy_q;

`ifdef BLUE_DOUBLE_JUMP_EN
    assign jump_edge = bus.key_jump & ~jump_prev_q & armed_q;
`endif

    // Vertical jump FSM: next state, next y and next vertical speed.
    always_comb begin
        vs_d = vs_q;
        y_d  = y_q;
        vy_d = vy_q;
`ifdef BLUE_DOUBLE_JUMP_EN
        jump_prev_d = jump_prev_q;
        armed_d     = armed_q;
`endif
        if (tick) begin
            case (vs_q)
                ST_GROUND: begin
                    if (bus.key_jump) begin
                        vs_d = ST_RISE;
                        vy_d = V0;
                    end
                end
                ST_RISE: begin
                    // Clamp at the top of the screen instead of going negative.
                    if (y_q < vy_q) begin
                        y_d  = '0;
                        vy_d = '0;
                        vs_d = ST_FALL;
                    end else begin
                        y_d  = y_q - vy_q;
                        vy_d = vy_dec;
                        if (vy_dec <= 12'sd0) begin
                            vs_d = ST_FALL;
                        end
                    end
                end
                ST_FALL: begin
                    if (y_sum >= Y_GND) begin
                        y_d  = Y_GND;
                        vy_d = '0;
                        vs_d = ST_GROUND;
                    end else begin
                        y_d  = y_sum;
                        vy_d = (vy_inc > V0) ? V0 : vy_inc;
                    end
                end
                default: begin
                    vs_d = ST_GROUND;
                    y_d  = Y_GND;
                    vy_d = '0;
                end
            endcase
`ifdef BLUE_DOUBLE_JUMP_EN
            // A landing tick takes priority; the re-jump only applies in the air.
            if ((vs_q != ST_GROUND) && (vs_d != ST_GROUND) && jump_edge) begin
                vs_d    = ST_RISE;
                y_d     = y_q;
                vy_d    = V0;
                armed_d = 1'b0;
            end
            if ((vs_q != ST_GROUND) && (vs_d == ST_GROUND)) begin
                armed_d = 1'b1;
            end
            jump_prev_d = bus.key_jump;
`endif
        end
    end

    // Motion state registers, updated only through the tick-gated next values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= 10'(X_INIT);
            facing_q <= 1'b1;
            move_q   <= 1'b0;
            vs_q     <= ST_GROUND;
            y_q      <= Y_GND;
            vy_q     <= '0;
        end else begin
            x_q      <= x_d;
            facing_q <= facing_d;
            move_q   <= move_d;
            vs_q     <= vs_d;
            y_q      <= y_d;
            vy_q     <= vy_d;
        end
    end

`ifdef BLUE_DOUBLE_JUMP_EN
    // Previous tick-sampled jump key and the once-per-airtime allowance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_prev_q <= 1'b0;
            armed_q     <= 1'b1;
        end else begin
            jump_prev_q <= jump_prev_d;
            armed_q     <= armed_d;
        end
    end
`endif

    // Sprite hit test and row-major ROM address for the current scan pixel.
    always_comb begin
        logic [10:0] col_e, row_e, px_e, py_e;
        logic [9:0]  dx, dy;
        logic        in_x, in_y;
        col_e     = {1'b0, bus.col};
        row_e     = {1'b0, bus.row};
        px_e      = {1'b0, x_q};
        py_e      = {1'b0, y_q[9:0]};
        in_x      = (col_e >= px_e) && (col_e < px_e + 11'(SPR_W));
        in_y      = (row_e >= py_e) && (row_e < py_e + 11'(SPR_H));
        dx        = bus.col - x_q;
        dy        = bus.row - y_q[9:0];
        blue_on_d = in_x && in_y;
        blue_d    = '0;
        if (in_x && in_y) begin
            blue_d = 12'(int'(dy) * SPR_W + int'(dx));
        end
    end

    // Address output registers: one clock behind col/row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blue_q    <= '0;
            blue_on_q <= 1'b0;
        end else begin
            blue_q    <= blue_d;
            blue_on_q <= blue_on_d;
        end
    end

    assign bus.blue       = blue_q;
    assign bus.blue_on    = blue_on_q;
    assign bus.pos_x      = x_q;
    assign bus.pos_y      = y_q[9:0];
    assign bus.blue_state = {(vs_q != ST_GROUND) ? 2'b10 : (move_q ? 2'b01 : 2'b00),
                             facing_q};

endmodule
